// File: rtl/execute_multdiv.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit for the execute stage.
// Stalls the front of the pipeline for 33 cycles and pulses result_ready for one cycle in DONE.
module execute_multdiv #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_Execute,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_ready,
    output logic        exception,
    output logic [31:0] rstatus_value
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [32:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        qm1_q, qm1_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        div_op_q, div_op_d;

    logic        is_mul, is_div, start, last_iter;
    logic [31:0] mag_in_a, mag_b, quot_fixed;
    logic [32:0] m_ext, booth_sum, rem_shift, diff;
    logic [63:0] product;
    logic [31:0] div_lo_n;
    logic        unused_ir;

    assign is_mul    = (IR_Execute[31:27] == 5'b00000) && (IR_Execute[6:2] == 5'b00110);
    assign is_div    = (IR_Execute[31:27] == 5'b00000) && (IR_Execute[6:2] == 5'b00111);
    assign start     = (state_q == S_IDLE) && (is_mul || is_div);
    assign last_iter = (count_q == 6'(ITER - 1));
    assign unused_ir = ^{IR_Execute[26:7], IR_Execute[1:0]};

    assign mag_in_a = operandA[31] ? -operandA : operandA;
    assign mag_b    = b_q[31] ? -b_q : b_q;

    // Booth step: accumulator carries a 33rd bit so subtracting -2^31 cannot overflow.
    assign m_ext = {a_q[31], a_q};
    always_comb begin
        booth_sum = hi_q;
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = hi_q + m_ext;
            2'b10:   booth_sum = hi_q - m_ext;
            default: booth_sum = hi_q;
        endcase
    end
    assign product = {booth_sum, lo_q[31:1]};

    // Restoring step: remainder lives in hi_q, dividend shifts out of / quotient into lo_q.
    assign rem_shift  = {hi_q[31:0], lo_q[31]};
    assign diff       = rem_shift - {1'b0, mag_b};
    assign div_lo_n   = {lo_q[30:0], ~diff[32]};
    assign quot_fixed = (a_q[31] ^ b_q[31]) ? -div_lo_n : div_lo_n;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        exc_d    = exc_q;
        div_op_d = div_op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = operandA;
                    b_d      = operandB;
                    count_d  = 6'd0;
                    hi_d     = 33'd0;
                    qm1_d    = 1'b0;
                    lo_d     = is_div ? mag_in_a : operandB;
                    div_op_d = is_div;
                    state_d  = is_div ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                hi_d    = {booth_sum[32], booth_sum[32:1]};
                lo_d    = {booth_sum[0], lo_q[31:1]};
                qm1_d   = lo_q[0];
                count_d = count_q + 6'd1;
                if (last_iter) begin
                    state_d  = S_DONE;
                    result_d = product[31:0];
                    exc_d    = (product[63:32] != {32{product[31]}});
                end
            end
            S_DIV: begin
                hi_d    = diff[32] ? rem_shift : diff;
                lo_d    = div_lo_n;
                count_d = count_q + 6'd1;
                if (last_iter) begin
                    state_d = S_DONE;
                    if (b_q == 32'd0) begin
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = quot_fixed;
                        exc_d    = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
                    end
                end
            end
            S_DONE: begin
                // Never restart from DONE; the instruction still in X has already issued.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= 6'd0;
            hi_q     <= 33'd0;
            lo_q     <= 32'd0;
            qm1_q    <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            div_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            div_op_q <= div_op_d;
        end
    end

    assign stall         = start || (state_q == S_MUL) || (state_q == S_DIV);
    assign result_ready  = (state_q == S_DONE);
    assign result        = result_q;
    assign exception     = result_ready && exc_q;
    assign rstatus_value = exception ? (div_op_q ? 32'd5 : 32'd4) : 32'd0;

endmodule

// File: tb/tb_execute_multdiv.sv
// Directed and randomized checks of execute_multdiv against a plain-arithmetic model.
module tb_execute_multdiv;

    logic        clock;
    logic        reset;
    logic [31:0] IR_Execute;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        stall;
    logic [31:0] result;
    logic        result_ready;
    logic        exception;
    logic [31:0] rstatus_value;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    execute_multdiv #(.ITER(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .IR_Execute    (IR_Execute),
        .operandA      (operandA),
        .operandB      (operandB),
        .stall         (stall),
        .result        (result),
        .result_ready  (result_ready),
        .exception     (exception),
        .rstatus_value (rstatus_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // R-type encoding with random filler in the fields the unit does not decode.
    function automatic logic [31:0] enc(input logic dv);
        logic [19:0] filler;
        filler = 20'($urandom);
        return {5'b00000, filler, (dv ? 5'b00111 : 5'b00110), 2'b00};
    endfunction

    // Returns {exception, result}.
    function automatic logic [32:0] ref_op(input logic dv, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q;
        if (!dv) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p != longint'($signed(p[31:0]))), p[31:0]};
        end
        if (b == 32'd0)
            return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Called just after a negedge with the unit idle; returns at cycle 33 (DONE) with IR set to nop.
    task automatic do_op(input logic dv, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, input string tag);
        logic [32:0] exp;
        int          bad;
        exp        = ref_op(dv, a, b);
        IR_Execute = enc(dv);
        operandA   = a;
        operandB   = b;
        #1;
        check({tag, "_start_stall"}, 32'(stall), 32'd1);
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clock);
            if (scramble) begin
                operandA = $urandom;
                operandB = $urandom;
            end
            #1;
            if (stall !== 1'b1 || result_ready !== 1'b0) bad++;
        end
        check({tag, "_busy_cycles_bad"}, 32'(bad), 32'd0);
        @(negedge clock);
        IR_Execute = 32'd0;
        #1;
        check({tag, "_ready"}, 32'(result_ready), 32'd1);
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
        check({tag, "_result"}, result, exp[31:0]);
        check({tag, "_exception"}, 32'(exception), 32'(exp[32]));
        check({tag, "_rstatus"}, rstatus_value, exp[32] ? (dv ? 32'd5 : 32'd4) : 32'd0);
        $display("op %s div=%0b a=%h b=%h -> result=%h exc=%0b rstatus=%0d",
                 tag, dv, a, b, result, exception, rstatus_value);
    endtask

    initial begin
        logic        dv;
        logic [31:0] ra, rb;
        int          pick;

        reset      = 1'b1;
        IR_Execute = 32'd0;
        operandA   = 32'd0;
        operandB   = 32'd0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ready", 32'(result_ready), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_exception", 32'(exception), 32'd0);
        check("rst_rstatus", rstatus_value, 32'd0);
        reset = 1'b0;

        @(negedge clock);
        #1;
        check("idle_nop_stall", 32'(stall), 32'd0);

        @(negedge clock);
        do_op(1'b0, 32'd7, -32'sd3, 1'b0, "mul_7_m3");
        @(negedge clock);
        do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul_ovf");
        @(negedge clock);
        do_op(1'b1, -32'sd7, 32'd2, 1'b0, "div_m7_2");
        @(negedge clock);
        do_op(1'b1, 32'd100, 32'd0, 1'b0, "div_by0");
        @(negedge clock);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_minovf");
        @(negedge clock);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, "mul_minmin");

        for (int i = 0; i < 12; i++) begin
            dv   = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 3);
            ra   = $urandom;
            rb   = $urandom;
            if (pick == 1) begin
                ra = 32'($signed($urandom_range(0, 200)) - 100);
                rb = 32'($signed($urandom_range(0, 200)) - 100);
            end else if (pick == 2) begin
                rb = 32'd0;
            end else if (pick == 3) begin
                ra = 32'($signed($urandom_range(0, 65535)) - 32768);
            end
            @(negedge clock);
            do_op(dv, ra, rb, 1'b1, $sformatf("rand%0d", i));
        end

        // Back-to-back: DONE must not restart even with div already present in X.
        @(negedge clock);
        do_op(1'b0, 32'd6, 32'd7, 1'b0, "b2b_mul");
        IR_Execute = enc(1'b1);
        operandA   = 32'd42;
        operandB   = 32'd6;
        #1;
        check("b2b_no_restart_stall", 32'(stall), 32'd0);
        @(negedge clock);
        do_op(1'b1, 32'd42, 32'd6, 1'b0, "b2b_div");

        @(negedge clock);
        #1;
        check("idle_hold_result", result, 32'd7);
        check("idle_hold_ready", 32'(result_ready), 32'd0);
        check("idle_hold_stall", 32'(stall), 32'd0);

        // Abort a mul with reset during its cycle 10, then restart from the held instruction.
        IR_Execute = enc(1'b0);
        operandA   = 32'd5;
        operandB   = 32'd9;
        #1;
        check("abort_start_stall", 32'(stall), 32'd1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("abort_ready", 32'(result_ready), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_exception", 32'(exception), 32'd0);
        check("abort_rstatus", rstatus_value, 32'd0);
        reset = 1'b0;
        do_op(1'b0, 32'd5, 32'd9, 1'b0, "restart_mul");

        @(negedge clock);
        #1;
        check("final_idle_ready", 32'(result_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
